// File: rtl/demux_dispatch_1to16_if.sv
// demux_dispatch_1to16_if: stream input, one-hot per-channel output and status bundle
interface demux_dispatch_1to16_if #(
  parameter int width = 8,
  parameter int snum  = 4
);
  localparam int N = 2 ** snum;
  logic             mode;
  logic [N-1:0]     en_mask;
  logic [width-1:0] in_data;
  logic [snum-1:0]  in_dest;
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] out_data;
  logic [N-1:0]     out_valid;
  logic [N-1:0]     out_ready;
  logic [snum-1:0]  cur_sel;
  logic             busy;
  logic [7:0]       drop_cnt;
  modport slave (
    input  mode, en_mask, in_data, in_dest, in_valid, out_ready,
    output in_ready, out_data, out_valid, cur_sel, busy, drop_cnt
  );
  modport master (
    output mode, en_mask, in_data, in_dest, in_valid, out_ready,
    input  in_ready, out_data, out_valid, cur_sel, busy, drop_cnt
  );
endinterface

// File: rtl/demux_dispatch_1to16.sv
// demux_dispatch_1to16: steers a valid/ready byte stream to 16 channels, addressed or round-robin
module demux_dispatch_1to16 #(
  parameter int width = 8,
  parameter int snum  = 4
) (
  input logic clk,
  input logic rst,
  demux_dispatch_1to16_if.slave bus
);
  localparam int N = 2 ** snum;
  logic [N-1:0]     valid_q, valid_d;
  logic [width-1:0] data_q, data_d;
  logic [snum-1:0]  sel_q, sel_d, ptr_q, ptr_d, rr_tgt, tgt;
  logic [7:0]       drop_q, drop_d;
  logic             busy, xfer, eligible, accept, present;
  always_comb begin
    rr_tgt = ptr_q;
    // descending scan so the nearest enabled channel from ptr wins
    for (int i = N - 1; i >= 0; i--)
      if (bus.en_mask[ptr_q + snum'(i)]) rr_tgt = ptr_q + snum'(i);
    busy     = |valid_q;
    xfer     = |(valid_q & bus.out_ready);
    eligible = !bus.mode || (|bus.en_mask);
    accept   = bus.in_valid && bus.in_ready;
    tgt      = bus.mode ? rr_tgt : bus.in_dest;
    present  = bus.mode || bus.en_mask[bus.in_dest];
    valid_d  = (accept && present) ? ({{(N-1){1'b0}}, 1'b1} << tgt) : (xfer ? '0 : valid_q);
    data_d   = (accept && present) ? bus.in_data : data_q;
    sel_d    = (accept && present) ? tgt : sel_q;
    ptr_d    = (accept && bus.mode) ? tgt + 1'b1 : ptr_q;
    drop_d   = (accept && !present && !(&drop_q)) ? drop_q + 8'd1 : drop_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      drop_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      drop_q  <= drop_d;
    end
  end
  assign bus.in_ready  = !rst && (!busy || xfer) && eligible;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.cur_sel   = busy ? sel_q : ptr_q;
  assign bus.busy      = busy;
  assign bus.drop_cnt  = drop_q;
endmodule

// File: doc/demux_dispatch_1to16.md
Name: demux_dispatch_1to16

Overview:
- Sequencing controller for the 8-bit 1-to-16 demux datapath. Accepts a valid/ready byte stream and steers each beat to one of 16 destination channels.
- Destination is either the beat's own address (addressed mode) or a round-robin pointer that skips disabled channels (RR mode).
- Output is a registered, one-entry stage: one shared data bus plus a one-hot per-channel valid with per-channel ready back-pressure.

Parameters:
- width, 8, data width of each beat.
- snum, 4, select width. Channel count is N = 2**snum = 16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; single clock domain; synchronous, active-high.
- mode  input  1  0 = addressed (use in_dest), 1 = round-robin. Sampled per accepted beat.
- en_mask  input  16  per-channel enable; bit k = 1 means channel k is eligible.
- in_data  input  width  input beat.
- in_dest  input  snum  destination for addressed mode; ignored in RR mode.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- out_data  output  width  registered beat on the shared output bus.
- out_valid  output  16  one-hot; bit k = 1 means out_data is presented to channel k.
- out_ready  input  16  per-channel sink ready.
- cur_sel  output  snum  channel index of the held beat; RR pointer value when empty.
- busy  output  1  held beat pending (equals |out_valid).
- drop_cnt  output  8  saturating count of addressed-mode beats dropped because their channel is disabled.

Behaviour:
- Reset (synchronous, rst = 1 at a clk edge):
  - out_valid = 0, out_data = 0, cur_sel = 0, RR pointer = 0, drop_cnt = 0, busy = 0.
  - in_ready is forced to 0 while rst is high.
- Handshake terms:
  - accept = in_valid & in_ready.
  - xfer = |(out_valid & out_ready). Only the asserted out_valid bit's ready matters.
  - in_ready = !busy | xfer, ANDed with eligibility. This is combinational from out_ready, which gives 1 beat/cycle throughput when the sink keeps ready high.
- Eligibility:
  - Addressed mode: always eligible.
  - RR mode: eligible only when en_mask != 0. With en_mask == 0 in RR mode, in_ready = 0.
- Target selection at accept:
  - Addressed mode: target = in_dest.
  - RR mode: target = first k with en_mask[k] = 1, searching ptr, ptr+1, ... with mod-16 wrap. The pointer then becomes (target + 1) mod 16.
  - The RR pointer does not advance in addressed mode.
- Latency: an accepted beat appears on out_data/out_valid on the next cycle.
  - out_valid[target] stays asserted and out_data stays stable until xfer.
  - Holding is unaffected by later en_mask changes.
- Simultaneous xfer and accept:
  - The held beat retires and the new beat loads in the same edge; busy stays 1.
  - xfer with no accept: out_valid -> 0 next cycle. out_data keeps its last value (don't-care).
- Drop rule (addressed mode, en_mask[in_dest] = 0):
  - The beat is accepted (in_ready as normal), not presented, and drop_cnt increments, saturating at 255.
  - A drop coinciding with an xfer leaves out_valid = 0 after the edge.
- cur_sel: target index while busy, RR pointer while empty.
- Mode switch takes effect on the next accepted beat. The RR pointer value is retained across modes.
- Reset mid-operation: any held beat is discarded; no out_valid pulse follows reset deassertion.
- No combinational path from in_valid to out_valid. out_valid is at most one-hot at all times.

Test Plan:
- Reset: rst high 2 cycles with in_valid = 1 -> in_ready = 0, out_valid = 16'h0000, drop_cnt = 0. First cycle after release: in_ready = 1.
- Addressed streaming, sink always ready: mode = 0, en_mask = 16'hFFFF, beats 8'hA0..8'hAF with dest 0..15 back-to-back -> out_valid = 1<<k with data 8'hA0+k exactly one cycle after each accept; no bubbles.
- Back-pressure: dest = 5, out_ready[5] = 0 for 3 cycles -> out_valid = 16'h0020 and out_data held stable, in_ready = 0. Raising out_ready[5] retires the beat and accepts the next one in the same cycle.
- RR skip and wrap: mode = 1, en_mask = 16'h8011, 5 beats -> targets 0, 4, 15, 0, 4. en_mask = 0 -> in_ready = 0.
- Drop: mode = 0, en_mask = 16'hFFFE, 300 beats to dest 0 -> no out_valid ever, drop_cnt saturates at 8'hFF.
- Reset mid-hold: beat held on channel 9 with out_ready[9] = 0, then assert rst -> out_valid = 0, cur_sel = 0, and the beat is never delivered.
